alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Command sequencer in front of ALU_TOP. Accepts one operation at a time
//  (A, B, ALU_FUN) over a valid/ready handshake and holds the ALU operands stable.
//  Waits out the ALU's registered latency, then captures the result and flag of
//  the addressed unit and returns them over a valid/ready response channel.
//  Sits between the system register/control FSM and ALU_TOP; it is the only driver of the ALU inputs.
// PARAMETERS
//  OPRND_W   16  ALU operand width (A, B, LOGIC/CMP/SHIFT outputs)
//  RES_W     32  ALU arithmetic result width; also response data width
//  ALU_LAT   1   ALU input-to-output latency in CLK cycles (>=1)
// PORTS
//  CLK          in   1        system clock
//  RST          in   1        async reset, active-low
//  CMD_VALID    in   1        command present
//  CMD_READY    out  1        controller can accept command
//  CMD_A        in   OPRND_W  operand A
//  CMD_B        in   OPRND_W  operand B
//  CMD_FUN      in   4        ALU function; [3:2] selects unit 00 arith,01 logic,10 cmp,11 shift
//  ALU_A        out  OPRND_W  to ALU_TOP.A
//  ALU_B        out  OPRND_W  to ALU_TOP.B
//  ALU_FUN      out  4        to ALU_TOP.ALU_FUN
//  ALU_CLK_EN   out  1        clock-gate enable for the ALU clock domain
//  ARITH_OUT    in   RES_W    from ALU; ARITH_FLAG, CARRY_OUT 1-bit companions
//  LOGIC_OUT/CMP_OUT/SHIFT_OUT  in OPRND_W  from ALU; matching *_FLAG 1-bit inputs
//  RSP_VALID    out  1        result available
//  RSP_READY    in   1        consumer takes result
//  RSP_DATA     out  RES_W    selected result, 16-bit units zero-extended
//  RSP_FLAG     out  1        selected unit's flag
//  RSP_CARRY    out  1        CARRY_OUT for arith ops, 0 otherwise
//  BUSY         out  1        high in any state except IDLE
// BEHAVIOUR
//  FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
//  Reset (RST=0, async): state IDLE; CMD_READY=0 during reset, =1 from first cycle after release.
//   RSP_VALID=0, RSP_DATA=0, RSP_FLAG=0, RSP_CARRY=0, BUSY=0, ALU_A/B/FUN=0, lat counter=0.
//  IDLE: CMD_READY=1. CMD_VALID&CMD_READY at an edge registers CMD_A/B/FUN into ALU_A/B/FUN
//   and moves to EXEC with counter=0. With no command, ALU_A/B/FUN hold their last values
//   (no operand toggling).
//  EXEC: ALU_* held constant; counter increments each cycle; leave to CAPT when counter==ALU_LAT-1.
//   EXEC lasts exactly ALU_LAT cycles.
//  CAPT: 1 cycle; ALU outputs are valid. At the exiting edge, load RSP_DATA/RSP_FLAG/RSP_CARRY per
//   ALU_FUN[3:2]. 00: ARITH_OUT/ARITH_FLAG/CARRY_OUT. 01: LOGIC. 10: CMP. 11: SHIFT.
//   Go to RESP.
//  RESP: RSP_VALID=1; RSP_* stable until RSP_READY=1 at an edge -> IDLE, RSP_VALID=0 next cycle.
//  Latency: RSP_VALID rises ALU_LAT+1 edges after the accepting edge (2 at ALU_LAT=1).
//  Throughput: CMD_READY=0 outside IDLE; CMD_VALID there is ignored and must be held by the source.
//   RSP_READY held high gives one op per ALU_LAT+3 cycles.
//  RSP_READY outside RESP is ignored. No command is accepted in the RESP->IDLE handover edge.
//  Reset mid-operation: the in-flight op is discarded and no response is produced.
//  Width rule: 16-bit results go into RSP_DATA[15:0]; [31:16]=0.
// CONFIGURATION
//  ALU_SEQ_CLK_GATE_EN defined: ALU_CLK_EN=1 only in EXEC and CAPT, registered so it is glitch-free.
//   It rises at the accepting edge and falls at the CAPT exit edge. Reset value 0.
//  Not defined: ALU_CLK_EN tied to 1 (ALU always clocked); all other behaviour identical.
// TESTING
//  1 Reset: assert RST=0 mid-EXEC -> all outputs 0 at once; after release CMD_READY=1, no RSP_VALID.
//  2 ADD: CMD_FUN=0000, A=16'h0005, B=16'h0003, RSP_READY=1 -> RSP_VALID 2 cycles after accept.
//    Response RSP_DATA=32'h0000_0008, RSP_CARRY=0.
//  3 MUL: CMD_FUN=0010, A=16'hFFFF, B=16'h0002 -> RSP_DATA=32'h0001_FFFE.
//    Logic op AND A=F0F0,B=FF00 -> RSP_DATA=32'h0000_F000.
//  4 Backpressure: RSP_READY=0 for 10 cycles -> RSP_VALID and RSP_DATA stable, CMD_READY=0.
//    A new CMD_VALID is not accepted until 1 cycle after RSP_READY=1.
//  5 Back-to-back: 4 cmds (one per unit group) with CMD_VALID held high, RSP_READY=1.
//    Responses arrive in order, spaced 4 cycles at ALU_LAT=1; each flag matches the unit model.
//  6 ALU_SEQ_CLK_GATE_EN on: ALU_CLK_EN high exactly 2 cycles per op at ALU_LAT=1,
//    3 at ALU_LAT=2, 0 while idle. Macro off: ALU_CLK_EN constant 1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: single-command sequencer in front of ALU_TOP.
// Accepts one operation over a valid/ready handshake and drives the ALU
// operands from registers. It waits ALU_LAT cycles, then captures the
// addressed unit's result and flag into a held response.
// Optional feature macro: ALU_SEQ_CLK_GATE_EN. When it is defined,
// o_alu_clk_en is a registered enable that is high only in EXEC and CAPT.
// When it is not defined, o_alu_clk_en is tied to 1.
module alu_seq_ctrl #(
   parameter int OPRND_W = 16,
   parameter int RES_W   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   // command channel
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [OPRND_W-1:0] i_cmd_a,
   input  logic [OPRND_W-1:0] i_cmd_b,
   input  logic [3:0]         i_cmd_fun,
   // ALU drive
   output logic [OPRND_W-1:0] o_alu_a,
   output logic [OPRND_W-1:0] o_alu_b,
   output logic [3:0]         o_alu_fun,
   output logic               o_alu_clk_en,
   // ALU results
   input  logic [RES_W-1:0]   i_arith_out,
   input  logic               i_arith_flag,
   input  logic               i_carry_out,
   input  logic [OPRND_W-1:0] i_logic_out,
   input  logic               i_logic_flag,
   input  logic [OPRND_W-1:0] i_cmp_out,
   input  logic               i_cmp_flag,
   input  logic [OPRND_W-1:0] i_shift_out,
   input  logic               i_shift_flag,
   // response channel
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [RES_W-1:0]   o_rsp_data,
   output logic               o_rsp_flag,
   output logic               o_rsp_carry,
   output logic               o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CAPT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);
   localparam int PAD_W = RES_W - OPRND_W;

   state_t             r_state;
   state_t             w_next_state;
   logic               r_ready_en;
   logic [CNT_W-1:0]   r_cnt;
   logic [OPRND_W-1:0] r_alu_a;
   logic [OPRND_W-1:0] r_alu_b;
   logic [3:0]         r_alu_fun;
   logic [RES_W-1:0]   r_rsp_data;
   logic               r_rsp_flag;
   logic               r_rsp_carry;
   logic               w_accept;
   logic [RES_W-1:0]   w_sel_data;
   logic               w_sel_flag;
   logic               w_sel_carry;

   // The ready gate stays low through reset and opens on the first edge after release.
   assign o_cmd_ready = (r_state == S_IDLE) && r_ready_en;
   assign w_accept    = i_cmd_valid && o_cmd_ready;

   // Next-state logic: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
   always_comb begin
      // NOTE: assign a default first so that no path through the block can infer a latch.
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = S_EXEC;
         S_EXEC: if (r_cnt == CNT_LAST) w_next_state = S_CAPT;
         S_CAPT: w_next_state = S_RESP;
         S_RESP: if (i_rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Result select by unit. The 16-bit units are zero-extended into the response width.
   always_comb begin
      w_sel_data  = i_arith_out;
      w_sel_flag  = i_arith_flag;
      w_sel_carry = 1'b0;
      case (r_alu_fun[3:2])
         2'b00: begin
            w_sel_data  = i_arith_out;
            w_sel_flag  = i_arith_flag;
            w_sel_carry = i_carry_out;
         end
         2'b01: begin
            w_sel_data = {{PAD_W{1'b0}}, i_logic_out};
            w_sel_flag = i_logic_flag;
         end
         2'b10: begin
            w_sel_data = {{PAD_W{1'b0}}, i_cmp_out};
            w_sel_flag = i_cmp_flag;
         end
         default: begin
            w_sel_data = {{PAD_W{1'b0}}, i_shift_out};
            w_sel_flag = i_shift_flag;
         end
      endcase
   end

   // Operand hold registers, latency counter and response capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ready_en  <= 1'b0;
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_fun   <= '0;
         r_rsp_data  <= '0;
         r_rsp_flag  <= 1'b0;
         r_rsp_carry <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            r_alu_a   <= i_cmd_a;
            r_alu_b   <= i_cmd_b;
            r_alu_fun <= i_cmd_fun;
            r_cnt     <= '0;
         end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == S_CAPT) begin
            r_rsp_data  <= w_sel_data;
            r_rsp_flag  <= w_sel_flag;
            r_rsp_carry <= w_sel_carry;
         end
      end
   end

`ifdef ALU_SEQ_CLK_GATE_EN
   logic r_alu_clk_en;

   // Registered gate enable. It goes high at the accepting edge and low at the CAPT exit edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_alu_clk_en <= 1'b0;
      else          r_alu_clk_en <= (w_next_state == S_EXEC) || (w_next_state == S_CAPT);
   end

   assign o_alu_clk_en = r_alu_clk_en;
`else
   assign o_alu_clk_en = 1'b1;
`endif

   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_fun   = r_alu_fun;
   assign o_rsp_valid = (r_state == S_RESP);
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_flag  = r_rsp_flag;
   assign o_rsp_carry = r_rsp_carry;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl at ALU_LAT=1.
// The bench contains a small registered ALU model that feeds the result inputs.
// All expected response values are hand-computed constants.
module tb_alu_seq_ctrl;

   localparam int OPRND_W = 16;
   localparam int RES_W   = 32;
   localparam int ALU_LAT = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [OPRND_W-1:0] cmd_a;
   logic [OPRND_W-1:0] cmd_b;
   logic [3:0]         cmd_fun;
   logic [OPRND_W-1:0] alu_a;
   logic [OPRND_W-1:0] alu_b;
   logic [3:0]         alu_fun;
   logic               alu_clk_en;
   logic [RES_W-1:0]   arith_out = '0;
   logic               arith_flag = 1'b0;
   logic               carry_out = 1'b0;
   logic [OPRND_W-1:0] logic_out = '0;
   logic               logic_flag = 1'b0;
   logic [OPRND_W-1:0] cmp_out = '0;
   logic               cmp_flag = 1'b0;
   logic [OPRND_W-1:0] shift_out = '0;
   logic               shift_flag = 1'b0;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [RES_W-1:0]   rsp_data;
   logic               rsp_flag;
   logic               rsp_carry;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.OPRND_W(OPRND_W), .RES_W(RES_W), .ALU_LAT(ALU_LAT)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_a      (cmd_a),
      .i_cmd_b      (cmd_b),
      .i_cmd_fun    (cmd_fun),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_fun    (alu_fun),
      .o_alu_clk_en (alu_clk_en),
      .i_arith_out  (arith_out),
      .i_arith_flag (arith_flag),
      .i_carry_out  (carry_out),
      .i_logic_out  (logic_out),
      .i_logic_flag (logic_flag),
      .i_cmp_out    (cmp_out),
      .i_cmp_flag   (cmp_flag),
      .i_shift_out  (shift_out),
      .i_shift_flag (shift_flag),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_data   (rsp_data),
      .o_rsp_flag   (rsp_flag),
      .o_rsp_carry  (rsp_carry),
      .o_busy       (busy)
   );

   // ALU_TOP stand-in with one registered stage. Each unit's flag marks that the unit was addressed.
   always_ff @(posedge clk) begin
      if (alu_clk_en) begin
         logic [16:0] sum;
         sum        = {1'b0, alu_a} + {1'b0, alu_b};
         arith_flag <= (alu_fun[3:2] == 2'b00);
         logic_flag <= (alu_fun[3:2] == 2'b01);
         cmp_flag   <= (alu_fun[3:2] == 2'b10);
         shift_flag <= (alu_fun[3:2] == 2'b11);
         carry_out  <= (alu_fun == 4'b0000) ? sum[16] : 1'b0;
         case (alu_fun[1:0])
            2'd0: arith_out <= 32'(sum);
            2'd1: arith_out <= 32'(alu_a) - 32'(alu_b);
            2'd2: arith_out <= 32'(alu_a) * 32'(alu_b);
            default: arith_out <= (alu_b != 0) ? 32'(alu_a / alu_b) : 32'd0;
         endcase
         case (alu_fun[1:0])
            2'd0: logic_out <= alu_a & alu_b;
            2'd1: logic_out <= alu_a | alu_b;
            2'd2: logic_out <= ~(alu_a & alu_b);
            default: logic_out <= ~(alu_a | alu_b);
         endcase
         case (alu_fun[1:0])
            2'd0: cmp_out <= 16'd0;
            2'd1: cmp_out <= (alu_a == alu_b) ? 16'd1 : 16'd0;
            2'd2: cmp_out <= (alu_a > alu_b) ? 16'd2 : 16'd0;
            default: cmp_out <= (alu_a < alu_b) ? 16'd3 : 16'd0;
         endcase
         case (alu_fun[1:0])
            2'd0: shift_out <= alu_a >> 1;
            2'd1: shift_out <= alu_a << 1;
            2'd2: shift_out <= alu_b >> 1;
            default: shift_out <= alu_b << 1;
         endcase
      end
   end

   // Presents a command at a negedge once ready is seen, then holds it across one edge.
   // The task returns at the negedge that follows the accepting edge.
   task automatic issue_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
      int guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_cmd_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      cmd_a     = a;
      cmd_b     = b;
      cmd_fun   = fun;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Counts the edges after the accepting edge until rsp_valid is seen. Returns -1 on timeout.
   task automatic wait_rsp(output int edges);
      edges = 0;
      while (!rsp_valid && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      if (!rsp_valid) edges = -1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_fun   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_ready, rsp_valid, busy, rsp_flag, rsp_carry} !== 5'b0 || rsp_data !== 32'd0 ||
          alu_a !== 16'd0 || alu_b !== 16'd0 || alu_fun !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%0b valid=%0b busy=%0b data=%h alu_a=%h required all 0",
                  cmd_ready, rsp_valid, busy, rsp_data, alu_a);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%0b valid=%0b busy=%0b required 1/0/0",
                  cmd_ready, rsp_valid, busy);
      end
   endtask

   task automatic test_add;
      int edges;
      rsp_ready = 1'b1;
      issue_cmd(16'h0005, 16'h0003, 4'b0000);
      n_checks++;
      if (busy !== 1'b1 || alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_fun !== 4'b0000) begin
         n_fail++;
         $display("FAIL add_operands: busy=%0b a=%h b=%h fun=%b required 1/0005/0003/0000",
                  busy, alu_a, alu_b, alu_fun);
      end
      wait_rsp(edges);
      n_checks++;
      if (edges != 2) begin
         n_fail++;
         $display("FAIL add_latency: %0d edges required 2", edges);
      end
      n_checks++;
      if (rsp_data !== 32'h0000_0008 || rsp_carry !== 1'b0 || rsp_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL add_result: data=%h carry=%0b flag=%0b required 00000008/0/1",
                  rsp_data, rsp_carry, rsp_flag);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL add_handover: valid=%0b ready=%0b required 0/1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_mul_logic;
      int edges;
      rsp_ready = 1'b1;
      issue_cmd(16'hFFFF, 16'h0002, 4'b0010);
      wait_rsp(edges);
      n_checks++;
      if (edges != 2 || rsp_data !== 32'h0001_FFFE || rsp_carry !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_result: edges=%0d data=%h carry=%0b required 2/0001fffe/0",
                  edges, rsp_data, rsp_carry);
      end
      @(negedge clk);
      issue_cmd(16'hF0F0, 16'hFF00, 4'b0100);
      wait_rsp(edges);
      n_checks++;
      if (edges != 2 || rsp_data !== 32'h0000_F000 || rsp_flag !== 1'b1 || rsp_carry !== 1'b0) begin
         n_fail++;
         $display("FAIL and_result: edges=%0d data=%h flag=%0b carry=%0b required 2/0000f000/1/0",
                  edges, rsp_data, rsp_flag, rsp_carry);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int edges;
      int bad;
      rsp_ready = 1'b0;
      issue_cmd(16'hFFFF, 16'h0001, 4'b0000);
      wait_rsp(edges);
      n_checks++;
      if (edges != 2 || rsp_data !== 32'h0001_0000 || rsp_carry !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_result: edges=%0d data=%h carry=%0b required 2/00010000/1",
                  edges, rsp_data, rsp_carry);
      end
      // A second command waits at the input while the response is held.
      cmd_a     = 16'h1234;
      cmd_b     = 16'h0001;
      cmd_fun   = 4'b0101;
      cmd_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h0001_0000 || cmd_ready !== 1'b0 ||
             alu_a !== 16'hFFFF) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL bp_handover: valid=%0b busy=%0b alu_a=%h required 0/0/ffff",
                  rsp_valid, busy, alu_a);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || alu_a !== 16'h1234 || alu_fun !== 4'b0101) begin
         n_fail++;
         $display("FAIL bp_next_accept: busy=%0b alu_a=%h fun=%b required 1/1234/0101",
                  busy, alu_a, alu_fun);
      end
      wait_rsp(edges);
      n_checks++;
      if (rsp_data !== 32'h0000_1235) begin
         n_fail++;
         $display("FAIL bp_next_result: data=%h required 00001235", rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [15:0] va   [4] = '{16'h0009, 16'h00F0, 16'h0007, 16'h8001};
      logic [15:0] vb   [4] = '{16'h0004, 16'h0F0F, 16'h0003, 16'h0000};
      logic [3:0]  vf   [4] = '{4'b0001, 4'b0101, 4'b1010, 4'b1101};
      logic [31:0] vexp [4] = '{32'h0000_0005, 32'h0000_0FFF, 32'h0000_0002, 32'h0000_0002};
      int idx    = 0;
      int nrsp   = 0;
      int last_t = -1;
      rsp_ready = 1'b1;
      for (int t = 0; t < 60 && nrsp < 4; t++) begin
         if (idx < 4) begin
            cmd_a     = va[idx];
            cmd_b     = vb[idx];
            cmd_fun   = vf[idx];
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         if (rsp_valid) begin
            n_checks++;
            if (rsp_data !== vexp[nrsp] || rsp_flag !== 1'b1 || rsp_carry !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_rsp%0d: data=%h flag=%0b carry=%0b required %h/1/0",
                        nrsp, rsp_data, rsp_flag, rsp_carry, vexp[nrsp]);
            end
            if (last_t >= 0) begin
               n_checks++;
               if (t - last_t != 4) begin
                  n_fail++;
                  $display("FAIL b2b_spacing%0d: %0d cycles required 4", nrsp, t - last_t);
               end
            end
            last_t = t;
            nrsp++;
         end
         if (cmd_valid && cmd_ready) idx++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      n_checks++;
      if (nrsp != 4) begin
         n_fail++;
         $display("FAIL b2b_count: %0d responses required 4", nrsp);
      end
      @(negedge clk);
   endtask

   task automatic test_clk_gate;
      int high = 0;
      int idle_high = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (alu_clk_en) idle_high++;
      end
      issue_cmd(16'h0001, 16'h0001, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         if (alu_clk_en) high++;
         @(negedge clk);
      end
`ifdef ALU_SEQ_CLK_GATE_EN
      n_checks++;
      if (idle_high != 0 || high != 2) begin
         n_fail++;
         $display("FAIL clk_gate: idle_high=%0d op_high=%0d required 0/2", idle_high, high);
      end
`else
      n_checks++;
      if (idle_high != 4 || high != 6) begin
         n_fail++;
         $display("FAIL clk_gate_tied: idle_high=%0d op_high=%0d required 4/6", idle_high, high);
      end
`endif
   endtask

   task automatic test_reset_mid_op;
      int seen = 0;
      rsp_ready = 1'b1;
      issue_cmd(16'hABCD, 16'h1111, 4'b0000);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cmd_ready, rsp_valid, busy, rsp_flag, rsp_carry} !== 5'b0 || rsp_data !== 32'd0 ||
          alu_a !== 16'd0 || alu_b !== 16'd0 || alu_fun !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: ready=%0b valid=%0b busy=%0b data=%h alu_a=%h required all 0",
                  cmd_ready, rsp_valid, busy, rsp_data, alu_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      n_checks++;
      if (seen != 0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_discard: rsp_valid cycles=%0d ready=%0b required 0/1", seen, cmd_ready);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul_logic();
      test_backpressure();
      test_back_to_back();
      test_clk_gate();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
